// File: rtl/counter_display_driver_if.sv
// rtl/counter_display_driver_if.sv - value/mode inputs and display/status outputs of counter_display_driver
interface counter_display_driver_if #(
   parameter int N      = 32,
   parameter int DIGITS = 8
);
   logic [N-1:0]      value;
   logic              hex_mode;
   logic              busy;
   logic              conv_valid;
   logic              overflow;
   logic [DIGITS-1:0] anodes;
   logic [6:0]        segments;
   logic              dp;

   // master drives the value being displayed, slave is the display driver
   modport master (output value, hex_mode,
                   input  busy, conv_valid, overflow, anodes, segments, dp);
   modport slave  (input  value, hex_mode,
                   output busy, conv_valid, overflow, anodes, segments, dp);
endinterface

// File: rtl/counter_display_driver.sv
// rtl/counter_display_driver.sv - binary-to-BCD/hex seven-segment scan driver; optional LEADING_ZERO_BLANK_EN blanks leading zeros
module counter_display_driver #(
   parameter int N           = 32,
   parameter int DIGITS      = 8,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                   clock,
   input  logic                   reset,
   counter_display_driver_if.slave bus
);
   localparam int BCD_DIGITS = (N * 3) / 10 + 1;
   localparam int SRW        = 4 * BCD_DIGITS + N;
   localparam int DW4        = 4 * DIGITS;
   localparam int XW_DEC     = (4 * BCD_DIGITS > DW4) ? 4 * BCD_DIGITS : DW4;
   localparam int XW_HEX     = (N > DW4) ? N : DW4;
   localparam int CW         = $clog2(N + 1);
   localparam int SW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state_q, state_d;
   logic [SRW-1:0]    sr_q, sr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [N-1:0]      val_q, val_d;
   logic              hex_q, hex_d;
   logic [DW4-1:0]    disp_q, disp_d;
   logic              ovf_q, ovf_d;
   logic              conv_q, conv_d;
   logic [SW-1:0]     scan_q, scan_d;
   logic [IW-1:0]     digit_q, digit_d;
   logic [DIGITS-1:0] anodes_q, anodes_d;
   logic [6:0]        seg_q, seg_d;

   logic [SRW-1:0]    sr_adj;
   logic [XW_DEC-1:0] bcd_ext;
   logic [XW_HEX-1:0] hex_ext;
   logic [DW4-1:0]    disp_sh;
   logic [3:0]        nib;
   logic              blank;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   // conversion FSM: capture in IDLE, double-dabble in SHIFT, latch display in DONE
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      val_d   = val_q;
      hex_d   = hex_q;
      disp_d  = disp_q;
      ovf_d   = ovf_q;
      conv_d  = 1'b0;
      sr_adj  = sr_q;
      for (int j = 0; j < BCD_DIGITS; j++) begin
         if (sr_q[N+4*j +: 4] >= 4'd5) sr_adj[N+4*j +: 4] = sr_q[N+4*j +: 4] + 4'd3;
      end
      bcd_ext = XW_DEC'(sr_q[SRW-1:N]);
      hex_ext = XW_HEX'(val_q);
      case (state_q)
         IDLE: begin
            val_d = bus.value;
            hex_d = bus.hex_mode;
            if (bus.hex_mode) begin
               state_d = DONE;
            end else begin
               sr_d    = SRW'(bus.value);
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sr_d = sr_adj << 1;
            if (cnt_q == CW'(N - 1)) state_d = DONE;
            else                     cnt_d   = cnt_q + CW'(1);
         end
         DONE: begin
            // digits beyond the displayed ones only feed the overflow flag
            if (hex_q) begin
               disp_d = hex_ext[DW4-1:0];
               ovf_d  = |(hex_ext >> DW4);
            end else begin
               disp_d = bcd_ext[DW4-1:0];
               ovf_d  = |(bcd_ext >> DW4);
            end
            conv_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // scan engine: dwell counter, digit index and registered anode/segment drive
   always_comb begin
      scan_d  = scan_q + SW'(1);
      digit_d = digit_q;
      if (scan_q == SW'(REFRESH_DIV - 1)) begin
         scan_d  = '0;
         digit_d = (digit_q == IW'(DIGITS - 1)) ? '0 : digit_q + IW'(1);
      end
      disp_sh = disp_q >> {digit_q, 2'b00};
      nib     = disp_sh[3:0];
      blank   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      // blank when this digit and every digit above it are zero; digit 0 always shows
      blank   = (digit_q != '0) && (disp_sh == '0);
`endif
      anodes_d = ~(DIGITS'(1) << digit_q);
      seg_d    = blank ? 7'h7F : seg7(nib);
   end

   // conversion state registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         val_q   <= '0;
         hex_q   <= 1'b0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
         conv_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
         hex_q   <= hex_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         conv_q  <= conv_d;
      end
   end

   // scan state and output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         scan_q   <= '0;
         digit_q  <= '0;
         anodes_q <= '1;
         seg_q    <= 7'h7F;
      end else begin
         scan_q   <= scan_d;
         digit_q  <= digit_d;
         anodes_q <= anodes_d;
         seg_q    <= seg_d;
      end
   end

   assign bus.busy       = (state_q != IDLE);
   assign bus.conv_valid = conv_q;
   assign bus.overflow   = ovf_q;
   assign bus.anodes     = anodes_q;
   assign bus.segments   = seg_q;
   assign bus.dp         = 1'b1;
endmodule

// File: tb/tb_counter_display_driver.sv
// tb/tb_counter_display_driver.sv - self-checking bench for counter_display_driver
module tb_counter_display_driver;
   localparam int N = 32;
   localparam int D = 8;
   localparam int R = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   counter_display_driver_if #(.N(N), .DIGITS(D)) bus ();
   counter_display_driver #(.N(N), .DIGITS(D), .REFRESH_DIV(R)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
   logic [7:0] an_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LEAD0 = 7'h7F;
`else
   localparam logic [6:0] LEAD0 = 7'b1000000;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic longint unsigned pow10(input int i);
      longint unsigned p = 1;
      for (int j = 0; j < i; j++) p = p * 10;
      return p;
   endfunction

   function automatic int nibble(input longint unsigned v, input bit hx, input int i);
      if (hx) return int'((v >> (4 * i)) & 64'hF);
      return int'((v / pow10(i)) % 10);
   endfunction

   function automatic logic [6:0] exp_seg(input longint unsigned v, input bit hx, input int i);
`ifdef LEADING_ZERO_BLANK_EN
      bit lead;
      lead = (i > 0);
      for (int j = i; j < D; j++) if (nibble(v, hx, j) != 0) lead = 1'b0;
      if (lead) return 7'h7F;
`endif
      return seg_tab[nibble(v, hx, i)];
   endfunction

   function automatic bit exp_ovf(input longint unsigned v, input bit hx);
      if (hx) return (v >> (4 * D)) != 0;
      return v >= pow10(D);
   endfunction

   // transaction-level model: capture instants, update instants and scan position from edge count
   int              k, next_cap, upd, md;
   longint unsigned cap_val, m_val;
   bit              cap_hex, m_hex, m_busy, m_conv, m_ovf;
   logic [7:0]      e_an;
   logic [6:0]      e_seg;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         k = 0; next_cap = 1; upd = -1;
         m_val = 0; m_hex = 0; m_busy = 0; m_conv = 0; m_ovf = 0;
         e_an = 8'hFF; e_seg = 7'h7F;
      end else begin
         k++;
         md    = ((k - 1) / R) % D;
         e_an  = ~(8'(1) << md);
         e_seg = exp_seg(m_val, m_hex, md);
         m_conv = 0;
         if (k == next_cap) begin
            cap_val = bus.value;
            cap_hex = bus.hex_mode;
            upd     = k + (cap_hex ? 1 : N + 1);
            m_busy  = 1;
         end
         if (k == upd) begin
            m_val    = cap_val;
            m_hex    = cap_hex;
            m_ovf    = exp_ovf(cap_val, cap_hex);
            m_conv   = 1;
            m_busy   = 0;
            next_cap = k + 1;
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clock) begin
      chk("anodes",     bus.anodes,     e_an);
      chk("segments",   bus.segments,   e_seg);
      chk("busy",       bus.busy,       m_busy);
      chk("conv_valid", bus.conv_valid, m_conv);
      chk("overflow",   bus.overflow,   m_ovf);
      chk("dp",         bus.dp,         1);
   end

   task automatic wait_conv(input string nm);
      int n = 0;
      do begin @(posedge clock); #1; n++; end while (!bus.conv_valid && n < 100);
      chk(nm, bus.conv_valid, 1);
   endtask

   task automatic check_digit(input int i, input logic [6:0] exp, input string nm);
      int n = 0;
      do begin @(posedge clock); #1; n++; end while (bus.anodes !== ~(8'(1) << i) && n < 40);
      chk(nm, {bus.anodes, 1'b0, bus.segments}, {~(8'(1) << i), 1'b0, exp});
   endtask

   task automatic count_to_conv(output int first);
      first = 0;
      for (int kk = 1; kk <= 40; kk++) begin
         @(posedge clock); #1;
         if (kk <= 33) chk("scan_seq", bus.anodes, an_tab[((kk - 1) / 4) % 8]);
         if (bus.conv_valid && first == 0) first = kk;
      end
   endtask

   int first;
   int p;

   initial begin
      bus.value    = 32;
      bus.hex_mode = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      chk("rst_anodes",   bus.anodes,     8'hFF);
      chk("rst_segments", bus.segments,   7'h7F);
      chk("rst_busy",     bus.busy,       0);
      chk("rst_conv",     bus.conv_valid, 0);
      chk("rst_overflow", bus.overflow,   0);
      chk("rst_dp",       bus.dp,         1);
      @(negedge clock); reset = 1'b1;
      count_to_conv(first);
      chk("dec_latency", first, 34);

      check_digit(0, 7'b0100100, "d32_digit0");
      check_digit(1, 7'b0110000, "d32_digit1");
      for (int i = 2; i < D; i++) check_digit(i, LEAD0, "d32_upper");
      chk("d32_overflow", bus.overflow, 0);

      @(negedge clock); bus.value = 32'hFFFFFFFF;
      wait_conv("max_conv_a"); wait_conv("max_conv_b");
      chk("max_overflow", bus.overflow, 1);
      check_digit(0, 7'b0010010, "max_digit0");
      check_digit(1, 7'b0010000, "max_digit1");
      check_digit(2, 7'b0100100, "max_digit2");
      check_digit(7, 7'b0010000, "max_digit7");

      @(negedge clock); bus.hex_mode = 1'b1; bus.value = 32'hDEADBEEF;
      wait_conv("hex_conv_a"); wait_conv("hex_conv_b"); wait_conv("hex_conv_c");
      p = 0;
      do begin @(posedge clock); #1; p++; end while (!bus.conv_valid && p < 100);
      chk("hex_period", p, 2);
      check_digit(7, 7'b0100001, "hex_digit7");
      check_digit(0, 7'b0001110, "hex_digit0");
      chk("hex_overflow", bus.overflow, 0);

      @(negedge clock); bus.hex_mode = 1'b0; bus.value = 32;
      wait_conv("chg_conv_a"); wait_conv("chg_conv_b"); wait_conv("chg_conv_c");
      repeat (6) @(posedge clock);
      #1 bus.value = 99;
      wait_conv("chg_conv_d");
      check_digit(1, 7'b0110000, "inflight_digit1");
      wait_conv("chg_conv_e");
      check_digit(0, 7'b0010000, "d99_digit0");
      check_digit(1, 7'b0010000, "d99_digit1");

      @(negedge clock); bus.value = 32'hFFFFFFFF;
      wait_conv("rst2_conv_a"); wait_conv("rst2_conv_b"); wait_conv("rst2_conv_c");
      repeat (5) @(posedge clock);
      #3 reset = 1'b0;
      #1;
      chk("arst_anodes",   bus.anodes,     8'hFF);
      chk("arst_segments", bus.segments,   7'h7F);
      chk("arst_busy",     bus.busy,       0);
      chk("arst_conv",     bus.conv_valid, 0);
      chk("arst_overflow", bus.overflow,   0);
      @(negedge clock); reset = 1'b1;
      count_to_conv(first);
      chk("arst_latency", first, 34);

      @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
